// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the sequential multiplier controller.
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } stateT;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_SETTLE_CYCLES = 4;
  localparam int COUNT_WIDTH           = 4;

  // Multiplier cell: partial-product AND feeding a full adder.
  // Returns {carryOut, sumOut}.
  function automatic logic [1:0] multCell(
    input logic aBit,
    input logic bBit,
    input logic sumIn,
    input logic carryIn
  );
    logic pp;
    pp = aBit & bBit;
    return {(pp & sumIn) | (pp & carryIn) | (sumIn & carryIn), pp ^ sumIn ^ carryIn};
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer and the multiplier.
interface mult_seq_ctrl_if
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic               inValid;
  logic               inReady;
  logic [WIDTH-1:0]   multiplicandIn;
  logic [WIDTH-1:0]   multiplierIn;
  logic               outValid;
  logic               outReady;
  logic [2*WIDTH-1:0] productOut;
  logic               busy;

  // Producer/consumer side.
  modport master (
    output inValid, multiplicandIn, multiplierIn, outReady,
    input  inReady, outValid, productOut, busy
  );

  // Multiplier side.
  modport slave (
    input  inValid, multiplicandIn, multiplierIn, outReady,
    output inReady, outValid, productOut, busy
  );
endinterface

// File: rtl/mult_seq_ctrl_array.sv
// Purely combinational unsigned WIDTH x WIDTH array multiplier built from multCell.
// Each row adds one partial product to the running upper partial sum and
// retires one low product bit.
module ArrayMultiplier
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : rowGen
    logic [WIDTH-1:0] upperIn;
    logic [WIDTH-1:0] upperOut;
    logic [WIDTH-1:0] rowSums;
    logic             rowCarry;
    logic [1:0]       cellOut;

    if (gi == 0) begin : firstRow
      assign upperIn = '0;
    end else begin : nextRow
      assign upperIn = rowGen[gi-1].upperOut;
    end

    // Ripple the cells of this row and shift the partial sum down by one bit.
    always_comb begin
      rowSums  = '0;
      rowCarry = 1'b0;
      cellOut  = '0;
      for (int j = 0; j < WIDTH; j++) begin
        cellOut    = multCell(multiplicand[j], multiplier[gi], upperIn[j], rowCarry);
        rowSums[j] = cellOut[0];
        rowCarry   = cellOut[1];
      end
      upperOut = {rowCarry, rowSums[WIDTH-1:1]};
    end

    assign product[gi] = rowSums[0];
  end

  assign product[2*WIDTH-1:WIDTH] = rowGen[WIDTH-1].upperOut;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential controller around a combinational array multiplier: captures an
// operand pair, waits a fixed settle time, registers the product and holds it
// until the consumer takes it.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input logic            clock,
  input logic            resetN,
  mult_seq_ctrl_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(SETTLE_CYCLES - 1);

  stateT                  stateReg;
  logic [COUNT_WIDTH-1:0] countReg;
  logic [WIDTH-1:0]       multiplicandReg;
  logic [WIDTH-1:0]       multiplierReg;
  logic [2*WIDTH-1:0]     productReg;
  logic [2*WIDTH-1:0]     arrayProduct;
  logic                   inReadyReg;
  logic                   outValidReg;
  logic                   busyReg;

  // Array inputs come only from the captured operands, which stay frozen until IDLE.
  ArrayMultiplier #(.WIDTH(WIDTH)) arrayMult (
    .multiplicand (multiplicandReg),
    .multiplier   (multiplierReg),
    .product      (arrayProduct)
  );

  // Control FSM; handshake outputs are registered alongside the state they decode.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      stateReg        <= IDLE;
      countReg        <= '0;
      multiplicandReg <= '0;
      multiplierReg   <= '0;
      productReg      <= '0;
      inReadyReg      <= 1'b1;
      outValidReg     <= 1'b0;
      busyReg         <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.inValid) begin
            multiplicandReg <= bus.multiplicandIn;
            multiplierReg   <= bus.multiplierIn;
            countReg        <= COUNT_LOAD;
            stateReg        <= SETTLE;
            inReadyReg      <= 1'b0;
            busyReg         <= 1'b1;
          end
        end
        SETTLE: begin
          if (countReg != '0) begin
            countReg <= countReg - 4'd1;
          end else begin
            productReg  <= arrayProduct;
            stateReg    <= DONE;
            outValidReg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.outReady) begin
            stateReg    <= IDLE;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
            busyReg     <= 1'b0;
          end
        end
        default: begin
          stateReg    <= IDLE;
          countReg    <= '0;
          inReadyReg  <= 1'b1;
          outValidReg <= 1'b0;
          busyReg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inReady    = inReadyReg;
  assign bus.outValid   = outValidReg;
  assign bus.busy       = busyReg;
  assign bus.productOut = productReg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios plus randomized
// traffic compared against an arithmetic reference (product = a*b, result
// appears SETTLE_CYCLES edges after acceptance).
module tb_mult_seq_ctrl;
  import mult_seq_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int S  = 4;
  localparam int W4 = 4;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  mult_seq_ctrl_if #(.WIDTH(W))  bus();
  mult_seq_ctrl_if #(.WIDTH(W))  busS1();
  mult_seq_ctrl_if #(.WIDTH(W4)) busW4();

  mult_seq_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  mult_seq_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dutS1 (
    .clock  (clock),
    .resetN (resetN),
    .bus    (busS1)
  );

  mult_seq_ctrl #(.WIDTH(W4), .SETTLE_CYCLES(S)) dutW4 (
    .clock  (clock),
    .resetN (resetN),
    .bus    (busW4)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    bus.inValid = 1'b0;   bus.multiplicandIn = '0;   bus.multiplierIn = '0;   bus.outReady = 1'b0;
    busS1.inValid = 1'b0; busS1.multiplicandIn = '0; busS1.multiplierIn = '0; busS1.outReady = 1'b0;
    busW4.inValid = 1'b0; busW4.multiplicandIn = '0; busW4.multiplierIn = '0; busW4.outReady = 1'b0;
  endtask

  // Present a pair to the main DUT and let one edge accept it.
  task automatic acceptMain(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (bus.inReady !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    compared++;
    if (bus.inReady !== 1'b1) begin
      mismatched++;
      $display("FAIL accept_ready: inReady=%b required 1", bus.inReady);
    end
    bus.multiplicandIn = a;
    bus.multiplierIn   = b;
    bus.inValid        = 1'b1;
    tick();
    bus.inValid = 1'b0;
    compared++;
    if (bus.busy !== 1'b1 || bus.inReady !== 1'b0) begin
      mismatched++;
      $display("FAIL accept_taken: busy=%b inReady=%b required busy=1 inReady=0", bus.busy, bus.inReady);
    end
  endtask

  // Count edges until outValid; mode 1 toggles a 5x5 pair, mode 2 drives random noise.
  task automatic waitMain(input int mode, output int cycles);
    cycles = 0;
    while (bus.outValid !== 1'b1 && cycles < 40) begin
      if (mode == 1) begin
        bus.inValid        = ~bus.inValid;
        bus.multiplicandIn = 8'd5;
        bus.multiplierIn   = 8'd5;
      end else if (mode == 2) begin
        bus.inValid        = 1'($urandom_range(0, 1));
        bus.multiplicandIn = 8'($urandom);
        bus.multiplierIn   = 8'($urandom);
        bus.outReady       = 1'($urandom_range(0, 1));
      end
      tick();
      cycles++;
    end
    if (mode != 0) begin
      bus.inValid  = 1'b0;
      bus.outReady = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.inValid = 1'b1;   bus.multiplicandIn = 8'd9; bus.multiplierIn = 8'd9; bus.outReady = 1'b1;
    busS1.inValid = 1'b1; busW4.inValid = 1'b1;
    tick();
    tick();
    compared++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: inReady=%b outValid=%b busy=%b required 1/0/0", bus.inReady, bus.outValid, bus.busy);
    end
    compared++;
    if (bus.productOut !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_product: productOut=%h required 0000", bus.productOut);
    end
    compared++;
    if (busS1.inReady !== 1'b1 || busW4.inReady !== 1'b1 || busW4.productOut !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_aux: s1.inReady=%b w4.inReady=%b w4.productOut=%h required 1/1/00",
               busS1.inReady, busW4.inReady, busW4.productOut);
    end
    resetN = 1'b1;
    idleInputs();
    tick();
    compared++;
    if (bus.inReady !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_hold: inReady=%b busy=%b required 1/0", bus.inReady, bus.busy);
    end
    $display("txn reset: inReady=%b outValid=%b productOut=%h", bus.inReady, bus.outValid, bus.productOut);
  endtask

  task automatic test_basic();
    int lat;
    bus.outReady = 1'b1;
    acceptMain(8'd13, 8'd11);
    waitMain(0, lat);
    compared++;
    if (lat != S) begin
      mismatched++;
      $display("FAIL basic_latency: %0d cycles required %0d", lat, S);
    end
    compared++;
    if (bus.productOut !== 16'd143) begin
      mismatched++;
      $display("FAIL basic_product: productOut=%0d required 143", bus.productOut);
    end
    tick();
    compared++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_return: outValid=%b inReady=%b required 0/1", bus.outValid, bus.inReady);
    end
    $display("txn 13*11 -> %0d latency %0d", bus.productOut, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    bus.outReady = 1'b0;
    acceptMain(8'hFF, 8'hFF);
    waitMain(0, lat);
    compared++;
    if (lat != S) begin
      mismatched++;
      $display("FAIL bp_latency: %0d cycles required %0d", lat, S);
    end
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (bus.outValid !== 1'b1 || bus.productOut !== 16'hFE01) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: outValid=%b productOut=%h required 1/fe01", i, bus.outValid, bus.productOut);
      end
      tick();
    end
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    compared++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_deliver: outValid=%b inReady=%b required 0/1", bus.outValid, bus.inReady);
    end
    $display("txn ff*ff -> %h held 10 cycles", bus.productOut);
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    bus.outReady = 1'b1;
    acceptMain(8'd7, 8'd9);
    tick();
    resetN      = 1'b0;
    bus.inValid = 1'b1;
    tick();
    compared++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0 || bus.busy !== 1'b0 || bus.productOut !== 16'd0) begin
      mismatched++;
      $display("FAIL abort_state: inReady=%b outValid=%b busy=%b productOut=%h required 1/0/0/0000",
               bus.inReady, bus.outValid, bus.busy, bus.productOut);
    end
    resetN      = 1'b1;
    bus.inValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.outValid === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL abort_no_pulse: %0d outValid cycles required 0", pulses);
    end
    bus.outReady = 1'b0;
    $display("txn 7*9 aborted by reset, outValid cycles after reset %0d", pulses);
  endtask

  task automatic test_ignore_inputs();
    int lat;
    bus.outReady = 1'b0;
    acceptMain(8'd0, 8'd200);
    waitMain(1, lat);
    compared++;
    if (lat != S || bus.productOut !== 16'd0) begin
      mismatched++;
      $display("FAIL ignore_result: latency=%0d productOut=%0d required %0d/0", lat, bus.productOut, S);
    end
    bus.outReady = 1'b1;
    tick();
    compared++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0) begin
      mismatched++;
      $display("FAIL ignore_return: inReady=%b outValid=%b required 1/0", bus.inReady, bus.outValid);
    end
    tick();
    tick();
    compared++;
    if (bus.busy !== 1'b0 || bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
      mismatched++;
      $display("FAIL ignore_no_capture: busy=%b outValid=%b inReady=%b required 0/0/1",
               bus.busy, bus.outValid, bus.inReady);
    end
    bus.outReady = 1'b0;
    $display("txn 0*200 -> %0d with 5*5 toggled during settle", bus.productOut);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   pa [3];
    logic [W-1:0]   pb [3];
    logic [2*W-1:0] expected;
    logic           prevValid;
    logic           acceptNow;
    int idx = 0, seen = 0, cycle = 0, lastRise = 0;
    pa[0] = 8'd3; pa[1] = 8'd6; pa[2] = 8'd255;
    pb[0] = 8'd4; pb[1] = 8'd7; pb[2] = 8'd1;
    prevValid          = 1'b0;
    bus.outReady       = 1'b1;
    bus.multiplicandIn = pa[0];
    bus.multiplierIn   = pb[0];
    bus.inValid        = 1'b1;
    while (seen < 3 && cycle < 100) begin
      acceptNow = (bus.inReady === 1'b1) && (bus.inValid === 1'b1);
      tick();
      cycle++;
      if (acceptNow) begin
        idx++;
        if (idx < 3) begin
          bus.multiplicandIn = pa[idx];
          bus.multiplierIn   = pb[idx];
        end else begin
          bus.inValid = 1'b0;
        end
      end
      if (bus.outValid === 1'b1 && prevValid !== 1'b1) begin
        expected = (2*W)'(pa[seen]) * (2*W)'(pb[seen]);
        compared++;
        if (bus.productOut !== expected) begin
          mismatched++;
          $display("FAIL b2b_product[%0d]: productOut=%0d required %0d", seen, bus.productOut, expected);
        end
        if (seen > 0) begin
          compared++;
          if (cycle - lastRise != S + 2) begin
            mismatched++;
            $display("FAIL b2b_spacing[%0d]: %0d cycles required %0d", seen, cycle - lastRise, S + 2);
          end
        end
        $display("txn b2b %0d*%0d -> %0d at cycle %0d", pa[seen], pb[seen], bus.productOut, cycle);
        lastRise = cycle;
        seen++;
      end
      prevValid = bus.outValid;
    end
    compared++;
    if (seen != 3) begin
      mismatched++;
      $display("FAIL b2b_count: %0d results required 3", seen);
    end
    bus.inValid  = 1'b0;
    tick();
    tick();
    bus.outReady = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] expected;
    int lat, bp;
    bit stable;
    for (int t = 0; t < 20; t++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (t == 0) begin a = 8'd255; b = 8'd1; end
      if (t == 1) begin a = 8'd128; b = 8'd2; end
      expected     = (2*W)'(a) * (2*W)'(b);
      bp           = $urandom_range(0, 3);
      bus.outReady = 1'b0;
      acceptMain(a, b);
      waitMain(2, lat);
      compared++;
      if (lat != S) begin
        mismatched++;
        $display("FAIL rand_latency[%0d]: %0d cycles required %0d", t, lat, S);
      end
      compared++;
      if (bus.productOut !== expected) begin
        mismatched++;
        $display("FAIL rand_product[%0d]: %0d*%0d gave %0d required %0d", t, a, b, bus.productOut, expected);
      end
      stable = 1'b1;
      for (int j = 0; j < bp; j++) begin
        bus.inValid = 1'($urandom_range(0, 1));
        tick();
        if (bus.outValid !== 1'b1 || bus.productOut !== expected) stable = 1'b0;
      end
      compared++;
      if (!stable) begin
        mismatched++;
        $display("FAIL rand_hold[%0d]: result not held for %0d backpressure cycles, last outValid=%b productOut=%0d required 1/%0d",
                 t, bp, bus.outValid, bus.productOut, expected);
      end
      bus.inValid  = 1'b0;
      bus.outReady = 1'b1;
      tick();
      bus.outReady = 1'b0;
      compared++;
      if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
        mismatched++;
        $display("FAIL rand_deliver[%0d]: outValid=%b inReady=%b required 0/1", t, bus.outValid, bus.inReady);
      end
      $display("txn rand %0d*%0d -> %0d latency %0d backpressure %0d", a, b, expected, lat, bp);
    end
  endtask

  task automatic test_settle_one();
    int lat = 0;
    busS1.outReady       = 1'b1;
    busS1.multiplicandIn = 8'd13;
    busS1.multiplierIn   = 8'd11;
    busS1.inValid        = 1'b1;
    tick();
    busS1.inValid = 1'b0;
    while (busS1.outValid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    compared++;
    if (lat != 1 || busS1.productOut !== 16'd143) begin
      mismatched++;
      $display("FAIL s1_result: latency=%0d productOut=%0d required 1/143", lat, busS1.productOut);
    end
    tick();
    compared++;
    if (busS1.inReady !== 1'b1 || busS1.outValid !== 1'b0) begin
      mismatched++;
      $display("FAIL s1_return: inReady=%b outValid=%b required 1/0", busS1.inReady, busS1.outValid);
    end
    busS1.outReady = 1'b0;
    $display("txn settle1 13*11 -> %0d latency %0d", busS1.productOut, lat);
  endtask

  task automatic test_width_four();
    logic [W4-1:0]   a;
    logic [W4-1:0]   b;
    logic [2*W4-1:0] expected;
    int lat;
    for (int t = 0; t < 4; t++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      if (t == 0) begin a = 4'd15; b = 4'd15; end
      expected             = (2*W4)'(a) * (2*W4)'(b);
      busW4.outReady       = 1'b1;
      busW4.multiplicandIn = a;
      busW4.multiplierIn   = b;
      busW4.inValid        = 1'b1;
      tick();
      busW4.inValid = 1'b0;
      lat = 0;
      while (busW4.outValid !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      compared++;
      if (lat != S || busW4.productOut !== expected) begin
        mismatched++;
        $display("FAIL w4_result[%0d]: %0d*%0d latency=%0d productOut=%0d required %0d/%0d",
                 t, a, b, lat, busW4.productOut, S, expected);
      end
      tick();
      $display("txn w4 %0d*%0d -> %0d latency %0d", a, b, busW4.productOut, lat);
    end
    busW4.outReady = 1'b0;
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_abort();
    test_ignore_inputs();
    test_back_to_back();
    test_random();
    test_settle_one();
    test_width_four();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001: Parameter WIDTH, default 8: operand width in bits; legal range 2..16.
REQ-002: Parameter SETTLE_CYCLES, default 4: cycles allowed for the combinational array to settle; legal range 1..15.
REQ-003: clock  input  1  sole clock; all state changes on rising edge.
REQ-004: resetN  input  1  reset, synchronous, active-low.
REQ-005: inValid  input  1  operand pair on multiplicandIn/multiplierIn is valid.
REQ-006: inReady  output  1  block can accept an operand pair this cycle.
REQ-007: multiplicandIn  input  WIDTH  unsigned multiplicand.
REQ-008: multiplierIn  input  WIDTH  unsigned multiplier.
REQ-009: outValid  output  1  productOut holds a completed result.
REQ-010: outReady  input  1  consumer accepts productOut this cycle.
REQ-011: productOut  output  2*WIDTH  registered unsigned product.
REQ-012: busy  output  1  high in any state other than IDLE.

Function
REQ-013: Three-state FSM, states IDLE, SETTLE and DONE, SHALL control operation.
REQ-014: inReady SHALL be high only in IDLE; outValid SHALL be high only in DONE; busy SHALL equal not-IDLE.
REQ-015: In IDLE, inValid=1 at an edge: operands SHALL be captured into registers, countdown loaded with SETTLE_CYCLES-1, next state SETTLE.
REQ-016: In IDLE, inValid=0: state and operand registers SHALL hold.
REQ-017: Captured operand registers SHALL be the only drivers of the array sub-module inputs and SHALL stay stable from capture until return to IDLE.
REQ-018: In SETTLE, countdown nonzero: decrement by 1 per edge.
REQ-019: In SETTLE, countdown zero: the array output SHALL be registered into productOut, next state DONE.
REQ-020: Latency: for an operand pair accepted at edge k, outValid SHALL first be high after edge k+SETTLE_CYCLES (edge 4 with defaults).
REQ-021: In DONE, productOut SHALL stay stable while outValid=1 and outReady=0 (unbounded backpressure).
REQ-022: In DONE, outReady=1: next state IDLE; inReady SHALL rise the following cycle. There is no same-cycle accept/deliver overlap, so peak throughput is one product per SETTLE_CYCLES+2 cycles.
REQ-023: inValid or input operand changes outside IDLE SHALL be ignored.
REQ-024: outReady while not in DONE SHALL be ignored.
REQ-025: productOut SHALL be the exact unsigned 2*WIDTH-bit product, with no truncation. Example: (2^WIDTH-1)^2 = 0xFE01 for WIDTH=8.
REQ-026: productOut SHALL retain the last delivered result in IDLE and SETTLE until overwritten per REQ-019.

Reset
REQ-027: When resetN=0 at an edge: state IDLE, countdown 0, operand registers 0, productOut 0. Therefore inReady=1, outValid=0 and busy=0 after that edge.
REQ-028: Reset in SETTLE or DONE SHALL abort the operation and discard any pending result. No outValid pulse SHALL follow the reset.
REQ-029: resetN SHALL take priority over all handshake inputs in the same cycle.

Structure
REQ-030: A shared package SHALL hold the FSM state enum (IDLE, SETTLE, DONE) and the default constants for WIDTH and SETTLE_CYCLES.
REQ-031: One sub-module, ArrayMultiplier, SHALL be instantiated. It is a purely combinational WIDTH x WIDTH unsigned array built from the existing multiplier cell, taking the registered operands and producing the 2*WIDTH-bit product.
REQ-032: The countdown register SHALL be 4 bits wide; the controller SHALL contain no other arithmetic.

Verification
REQ-033: Reset, then accept 8'd13 x 8'd11 with outReady=1 -> outValid high after edge 4 with productOut=16'd143; inReady returns high one cycle after delivery.
REQ-034: Accept 8'hFF x 8'hFF, hold outReady=0 for 10 cycles -> productOut stays 16'hFE01 with outValid=1 throughout; delivered on the first outReady=1.
REQ-035: Accept 8'd0 x 8'd200, then toggle inValid with 8'd5 x 8'd5 during SETTLE -> result 16'd0; the second pair is never captured.
REQ-036: Assert resetN=0 two cycles after accepting 8'd7 x 8'd9 -> no outValid pulse, inReady=1 and productOut=0 after the reset edge.
REQ-037: Back-to-back pairs (3x4, 6x7, 255x1) with inValid held high and outReady=1 -> outputs 12, 42 and 255 in order, each SETTLE_CYCLES+2 cycles apart.
REQ-038: Repeat REQ-033 with SETTLE_CYCLES=1 and with WIDTH=4 (15x15 -> 8'd225) -> latency of 1 cycle and exact product respectively.
